sha256_round_ctrl: RTL and testbench
====================================

# sha256_round_ctrl

Control FSM for the SHA-256 compression core; it sits directly upstream of the working-register bank and its select register. It accepts 512-bit message blocks through a valid/ready handshake and issues the one-cycle `start` load strobe and the `sel_A` IV-versus-chaining select. It then sequences the 64 rounds, the digest update, and the final digest-valid pulse. It handles multi-block messages by tracking whether a message is open.

## Interface
- `ROUNDS`, 64: rounds per block. Fixed for SHA-256; the parameter exists for bench shortening only.
- `CLK`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-high.
- `blk_valid`  in  1  message block (16 words) presented upstream.
- `blk_first`  in  1  qualifies `blk_valid`: this block is the first of a message.
- `blk_last`  in  1  qualifies `blk_valid`: this block is the last of a message.
- `blk_ready`  out  1  controller can accept a block.
- `start`  out  1  one-cycle strobe that loads the working registers A..H and the `sel_A` register.
- `sel_A`  out  1  valid with `start`. 1 = load the IV; 0 = load the previous digest.
- `round`  out  6  current round index t.
- `round_en`  out  1  compression round active this cycle.
- `w_sel`  out  1  1 when t<16 (take the message word directly); 0 = take the schedule word.
- `upd_en`  out  1  one-cycle strobe that adds A..H into H0..H7.
- `digest_valid`  out  1  one-cycle pulse: H0..H7 hold the final message digest.
- `busy`  out  1  high in every state except IDLE.
- `abort`  in  1  present only with `SHA256_CTRL_ABORT_EN`.

## Operation
- States: IDLE, LOAD, ROUND, UPDATE, DONE.
- IDLE
  - `blk_ready`=1.
  - Acceptance is `blk_valid & blk_ready`. On acceptance, latch `first_q` and `last_q`, then go to LOAD.
- LOAD (1 cycle)
  - `start`=1.
  - `sel_A`=1 if `first_q` or `msg_open`=0; otherwise 0.
  - Set `msg_open`=1. Clear `round` to 0. Go to ROUND.
- ROUND (exactly ROUNDS cycles)
  - `round_en`=1.
  - `round` increments 0..63. `w_sel` = (`round`<16).
  - At `round`=63, go to UPDATE and wrap `round` to 0.
- UPDATE (1 cycle)
  - `upd_en`=1.
  - If `last_q`: clear `msg_open`, go to DONE. Otherwise go to IDLE and wait for the next block.
- DONE (1 cycle): `digest_valid`=1, then go to IDLE.
- `blk_first` asserted while `msg_open`=1 abandons the open message: the block is loaded with `sel_A`=1.
- A non-first block arriving with `msg_open`=0 is treated as first: `sel_A`=1.
- A block with both `blk_first` and `blk_last` set is a single-block message.
- `blk_valid` outside IDLE is ignored. `blk_ready`=0, so upstream must hold the block.
- All strobes (`start`, `upd_en`, `digest_valid`) are registered outputs and are mutually exclusive.

## Timing
- Reset values: state=IDLE, `blk_ready`=1, `round`=0, `msg_open`=0, `first_q`=0, `last_q`=0. All other outputs are 0.
- Reset mid-operation returns to IDLE immediately. No `upd_en` or `digest_valid` is produced for the interrupted block.
- Acceptance edge = cycle 0. Then:
  - `start` in cycle 1.
  - `round_en` in cycles 2..65.
  - `upd_en` in cycle 66.
  - `digest_valid` in cycle 67 (last block only).
- Non-last block: `blk_ready` returns in cycle 67, giving a block throughput of 67 cycles.
- Last block: `blk_ready` returns in cycle 68.

## Configuration
- `SHA256_CTRL_ABORT_EN` defined:
  - `abort` port exists.
  - `abort`=1 sampled in any non-IDLE state forces IDLE on the next edge and clears `msg_open`.
  - No `upd_en` or `digest_valid` is issued for the aborted block.
  - `abort` takes priority over every other transition.
  - In IDLE, `abort` is ignored.
- Undefined: no `abort` port, and the FSM always runs a block to completion.

## Structure
- `sha256_pkg` holds:
  - the state enum;
  - `SHA256_ROUNDS`=64;
  - `SHA256_W_DIRECT`=16;
  - the round-index width (6).
- One sub-module, `sha256_round_cnt`: 6-bit counter with clear, enable, and a terminal-count output (t==ROUNDS-1). The FSM stays in this block.

## Test plan
- Reset released, one block with first=1, last=1 → `start`=1 with `sel_A`=1 at cycle 1, 64 `round_en` cycles with `round` 0..63 and `w_sel`=1 only for 0..15, `upd_en` at cycle 66, `digest_valid` at cycle 67.
- Three-block message (first, middle, last) → `sel_A` = 1, 0, 0 on the three `start`s. Only one `digest_valid`, after the third `upd_en`.
- `blk_valid` held high during ROUND → `blk_ready`=0 and no second `start` until cycle 67, then the block is accepted.
- `RST` pulsed at `round`=30 → all outputs at reset values. The next block has `sel_A`=1 and no stray `upd_en`.
- Open message, then a new block with `blk_first`=1 → `sel_A`=1.
- With `SHA256_CTRL_ABORT_EN`: `abort` at `round`=10 → IDLE next cycle, no `upd_en`. The next non-first block loads with `sel_A`=1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 controller constants and state encoding.
// Pure declarations; no latency and no flow control of its own.
package sha256_pkg;

    localparam int SHA256_ROUNDS   = 64;
    localparam int SHA256_W_DIRECT = 16;
    localparam int SHA256_RND_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROUND  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/sha256_round_cnt.sv
// Round index counter: clear has priority, wraps to 0 after ROUNDS-1.
// Count visible one cycle after enable; no flow control.
module sha256_round_cnt
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clr,
    input  logic                    en,
    output logic [SHA256_RND_W-1:0] cnt,
    output logic                    tc
);

    assign tc = (cnt == SHA256_RND_W'(ROUNDS - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + SHA256_RND_W'(1);
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block sequencer: start at +1, ROUNDS round cycles, upd_en, digest_valid on last block.
// blk_ready only in IDLE, so upstream holds the block; SHA256_CTRL_ABORT_EN adds an abort input.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    blk_valid,
    input  logic                    blk_first,
    input  logic                    blk_last,
`ifdef SHA256_CTRL_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    blk_ready,
    output logic                    start,
    output logic                    sel_A,
    output logic [SHA256_RND_W-1:0] round,
    output logic                    round_en,
    output logic                    w_sel,
    output logic                    upd_en,
    output logic                    digest_valid,
    output logic                    busy
);

    state_t state;
    state_t state_nxt;
    logic   first_q;
    logic   last_q;
    logic   msg_open;
    logic   accept;
    logic   abort_hit;
    logic   rnd_tc;

    // blk_ready is a flop that mirrors state==IDLE
    assign accept = blk_valid & blk_ready;

`ifdef SHA256_CTRL_ABORT_EN
    assign abort_hit = abort & (state != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_ROUND;
            ST_ROUND:  if (rnd_tc) state_nxt = ST_UPDATE;
            ST_UPDATE: state_nxt = last_q ? ST_DONE : ST_IDLE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort_hit) state_nxt = ST_IDLE;
    end

    sha256_round_cnt #(
        .ROUNDS (ROUNDS)
    ) u_cnt (
        .CLK (CLK),
        .RST (RST),
        .clr ((state == ST_LOAD) | abort_hit),
        .en  (state == ST_ROUND),
        .cnt (round),
        .tc  (rnd_tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            msg_open     <= 1'b0;
            blk_ready    <= 1'b1;
            start        <= 1'b0;
            round_en     <= 1'b0;
            upd_en       <= 1'b0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                first_q <= blk_first;
                last_q  <= blk_last;
            end
            if (abort_hit) begin
                msg_open <= 1'b0;
            end else if (state == ST_LOAD) begin
                msg_open <= 1'b1;
            end else if ((state == ST_UPDATE) && last_q) begin
                msg_open <= 1'b0;
            end
            blk_ready    <= (state_nxt == ST_IDLE);
            start        <= (state_nxt == ST_LOAD);
            round_en     <= (state_nxt == ST_ROUND);
            upd_en       <= (state_nxt == ST_UPDATE);
            digest_valid <= (state_nxt == ST_DONE);
            busy         <= (state_nxt != ST_IDLE);
        end
    end

    // msg_open still holds its pre-block value while start is high
    assign sel_A = start & (first_q | ~msg_open);
    assign w_sel = round_en & (round < SHA256_RND_W'(SHA256_W_DIRECT));

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: per-cycle reference model keyed on cycles since acceptance,
// a block table, hand-written corner sequences and randomized traffic.
`timescale 1ns/1ps
module tb_sha256_round_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       blk_valid = 1'b0;
    logic       blk_first = 1'b0;
    logic       blk_last = 1'b0;
`ifdef SHA256_CTRL_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       blk_ready, start, sel_A, round_en, w_sel, upd_en, digest_valid, busy;
    logic [5:0] round;

    sha256_round_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .blk_valid    (blk_valid),
        .blk_first    (blk_first),
        .blk_last     (blk_last),
`ifdef SHA256_CTRL_ABORT_EN
        .abort        (abort),
`endif
        .blk_ready    (blk_ready),
        .start        (start),
        .sel_A        (sel_A),
        .round        (round),
        .round_en     (round_en),
        .w_sel        (w_sel),
        .upd_en       (upd_en),
        .digest_valid (digest_valid),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    localparam logic [13:0] RST_VEC = 14'h2000;  // only blk_ready high

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model: m_k counts cycles since the acceptance edge (1 = start cycle)
    bit m_act  = 1'b0;
    bit m_last = 1'b0;
    bit m_sel  = 1'b0;
    bit m_open = 1'b0;
    int m_k    = 0;

    int t_start, t_upd, t_dv, n_start, n_upd, n_dv, n_re, n_ws;
    bit s_sel;

    typedef struct {
        bit first;
        bit last;
        bit exp_sel;
        int exp_dv;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), need %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [13:0] exp_vec();
        int         k;
        bit         re;
        logic [5:0] r;
        k  = m_act ? m_k : 0;
        re = (k >= 2) && (k <= 65);
        r  = re ? 6'(k - 2) : 6'd0;
        return {~m_act, (k == 1), (k == 1) & m_sel, r, re, re && (k - 2 < 16),
                (k == 66), (k == 67), m_act};
    endfunction

    function automatic logic [13:0] act_vec();
        return {blk_ready, start, start & sel_A, round, round_en, w_sel,
                upd_en, digest_valid, busy};
    endfunction

    task automatic clear_stats();
        n_start = 0; n_upd = 0; n_dv = 0; n_re = 0; n_ws = 0;
        t_start = -1; t_upd = -1; t_dv = -1; s_sel = 1'b0;
    endtask

    task automatic tick();
        bit acc;
        acc = !RST && !m_act && blk_valid;
        @(posedge CLK);
        #1;
        cyc++;
        if (RST) begin
            m_act  = 1'b0;
            m_open = 1'b0;
        end
`ifdef SHA256_CTRL_ABORT_EN
        else if (abort && m_act) begin
            m_act  = 1'b0;
            m_open = 1'b0;
        end
`endif
        else if (acc) begin
            m_act  = 1'b1;
            m_k    = 1;
            m_last = blk_last;
            m_sel  = blk_first | !m_open;
            m_open = 1'b1;
        end else if (m_act) begin
            m_k++;
            if (m_k == 67 && m_last) m_open = 1'b0;
            if (m_k > (m_last ? 67 : 66)) m_act = 1'b0;
        end
        check("cycle_outputs", 32'(act_vec()), 32'(exp_vec()));
        if (start) begin t_start = cyc; s_sel = sel_A; n_start++; end
        if (upd_en) begin t_upd = cyc; n_upd++; end
        if (digest_valid) begin t_dv = cyc; n_dv++; end
        if (round_en) n_re++;
        if (w_sel) n_ws++;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (blk_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (blk_ready !== 1'b1) bound_fail(name);
    endtask

    task automatic run_block(input bit f, input bit l, output int c0);
        wait_ready("wait_ready");
        c0 = cyc;
        blk_valid = 1'b1; blk_first = f; blk_last = l;
        tick();
        blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
        wait_ready("block_done");
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        #1;
        check("rst_async", 32'(act_vec()), 32'(RST_VEC));
        tick();
        RST = 1'b0;
    endtask

    initial begin
        int c0;
        int n;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1};

        clear_stats();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_values", 32'(act_vec()), 32'(RST_VEC));
        RST = 1'b0;
        tick();

        // single-block message timing
        clear_stats();
        run_block(1'b1, 1'b1, c0);
        check("single_start_cycle", t_start - c0, 1);
        check("single_sel_A", 32'(s_sel), 1);
        check("single_upd_cycle", t_upd - c0, 66);
        check("single_dv_cycle", t_dv - c0, 67);
        check("single_round_en_count", n_re, 64);
        check("single_w_sel_count", n_ws, 16);
        check("single_dv_count", n_dv, 1);

        // block table: multi-block, closed-message non-first, abandon by first
        for (int i = 0; i < 7; i++) begin
            clear_stats();
            run_block(vecs[i].first, vecs[i].last, c0);
            check($sformatf("vec%0d_sel_A", i), 32'(s_sel), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d_dv_count", i), n_dv, vecs[i].exp_dv);
            check($sformatf("vec%0d_upd_count", i), n_upd, 1);
            if (vecs[i].exp_dv != 0) check($sformatf("vec%0d_dv_after_upd", i), t_dv - t_upd, 1);
        end

        // blk_valid held through the rounds: next start exactly 67 cycles later
        clear_stats();
        wait_ready("bp_ready");
        c0 = cyc;
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b0;
        tick();
        blk_first = 1'b0; blk_last = 1'b1;
        n = 0;
        while (n_start < 2 && n < 100) begin tick(); n++; end
        if (n_start < 2) bound_fail("bp_second_start");
        else begin
            check("bp_start_gap", t_start - (c0 + 1), 67);
            check("bp_second_sel_A", 32'(s_sel), 0);
        end
        blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
        wait_ready("bp_done");

        // reset in the middle of the rounds
        wait_ready("rst_ready");
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b0;
        tick();
        blk_valid = 1'b0; blk_first = 1'b0;
        n = 0;
        while (!(round_en && round == 6'd30) && n < 100) begin tick(); n++; end
        if (!(round_en && round == 6'd30)) bound_fail("rst_reach_round30");
        clear_stats();
        pulse_reset();
        run_block(1'b0, 1'b1, c0);
        check("rst_next_sel_A", 32'(s_sel), 1);
        check("rst_upd_count", n_upd, 1);
        check("rst_dv_count", n_dv, 1);

`ifdef SHA256_CTRL_ABORT_EN
        wait_ready("abort_ready");
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b0;
        tick();
        blk_valid = 1'b0; blk_first = 1'b0;
        n = 0;
        while (!(round_en && round == 6'd10) && n < 100) begin tick(); n++; end
        clear_stats();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 32'(blk_ready), 1);
        run_block(1'b0, 1'b0, c0);
        check("abort_next_sel_A", 32'(s_sel), 1);
        check("abort_upd_count", n_upd, 1);
`endif

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            blk_valid = ($urandom_range(0, 3) != 0);
            blk_first = 1'($urandom_range(0, 1));
            blk_last  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 599) == 0) pulse_reset();
            else tick();
        end
        blk_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
